// File: rtl/pio_infra_multi.sv
// Multi-channel PIO for IR / sensor inputs on an Avalon-MM slave.
// Each channel is synchronised, glitch filtered and edge detected. Selected
// rising/falling edges are latched in a write-1-to-clear capture register,
// and the masked captures drive a single level interrupt.
module pio_infra_multi #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = (FILTER_LEN > 0) ? $clog2(FILTER_LEN + 1) : 1;

    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] rd_mux;
    logic             wr;

    assign wr = chipselect & ~write_n;

    // Metastability synchroniser: in_port shifts through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_chain[s] <= '0;
        end else begin
            sync_chain[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            // With no filtering the synchroniser output is used directly so the
            // bypass adds no latency on top of the synchroniser.
            assign filtered = sync;
        end else begin : g_filter
            logic [CNT_W-1:0] cnt [WIDTH];

            // Per-bit stability counter: filtered follows sync only after
            // FILTER_LEN consecutive mismatching cycles.
            always_ff @(posedge clk) begin
                if (reset) begin
                    filtered <= '0;
                    for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync[i] == filtered[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
                            filtered[i] <= sync[i];
                            cnt[i]      <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // Previous filtered level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) prev <= '0;
        else       prev <= filtered;
    end

    assign set_bits = (filtered & ~prev & rise_en) | (~filtered & prev & fall_en);
    assign clr_bits = (wr && address == 3'd3) ? writedata : '0;

    // Control registers and edge capture; a new edge beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            rise_en      <= '0;
            fall_en      <= '1;
            edge_capture <= '0;
        end else begin
            if (wr && address == 3'd2) irq_mask <= writedata;
            if (wr && address == 3'd4) rise_en  <= writedata;
            if (wr && address == 3'd5) fall_en  <= writedata;
            edge_capture <= set_bits | (edge_capture & ~clr_bits);
        end
    end

    // Read address decode.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = filtered;
            3'd1:    rd_mux = sync;
            3'd2:    rd_mux = irq_mask;
            3'd3:    rd_mux = edge_capture;
            3'd4:    rd_mux = rise_en;
            3'd5:    rd_mux = fall_en;
            3'd6:    rd_mux = edge_capture & irq_mask;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, updated every clock independent of chipselect.
    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_infra_multi.sv
// Testbench for pio_infra_multi: one filtered instance (FILTER_LEN=4) and one
// bypass instance (FILTER_LEN=0) sharing the address/data bus and inputs.
module tb_pio_infra_multi;

    localparam int S  = 2;
    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] address;
    logic       cs, cs0;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] in_port;
    logic [7:0] rd, rd0;
    logic       irq, irq0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_infra_multi #(.WIDTH(8), .SYNC_STAGES(S), .FILTER_LEN(FL)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs),
        .write_n(write_n), .writedata(writedata), .readdata(rd),
        .in_port(in_port), .irq(irq)
    );

    pio_infra_multi #(.WIDTH(8), .SYNC_STAGES(S), .FILTER_LEN(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .irq(irq0)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input bit sel, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = !sel; cs0 = sel; address = a; writedata = d; write_n = 1'b0;
        @(posedge clk);
        #1;
        write_n = 1'b1; cs = 1'b0; cs0 = 1'b0;
    endtask

    task automatic bus_read(input bit sel, input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = !sel; cs0 = sel; address = a; write_n = 1'b1;
        @(posedge clk);
        #1;
        d = sel ? rd0 : rd;
        cs = 1'b0; cs0 = 1'b0;
    endtask

    task automatic set_input(input logic [7:0] v, input int settle);
        @(negedge clk);
        in_port = v;
        cyc(settle);
    endtask

    task automatic test_reset();
        logic [7:0] exp_regs [8];
        logic [7:0] d;
        exp_regs = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        for (int a = 0; a < 8; a++) begin
            bus_read(1'b0, 3'(a), d);
            checks++;
            if (d !== exp_regs[a]) begin
                errors++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, exp_regs[a]);
            end
            bus_read(1'b1, 3'(a), d);
            checks++;
            if (d !== exp_regs[a]) begin
                errors++; $display("FAIL reset_bypass_reg%0d: got %h expected %h", a, d, exp_regs[a]);
            end
        end
        checks++;
        if (irq !== 1'b0 || irq0 !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b/%b expected 0/0", irq, irq0);
        end
    endtask

    task automatic test_rise_latency();
        logic [7:0] d;
        @(negedge clk);
        in_port = 8'h01; cs = 1'b1; address = 3'd0; write_n = 1'b1;
        @(posedge clk); #1;              // E0
        cyc(5);                          // E0+5: readdata shows filtered after E0+4
        checks++;
        if (rd !== 8'h00) begin
            errors++; $display("FAIL filt_early: got %h expected 00", rd);
        end
        cyc(1);                          // E0+6: readdata shows filtered after E0+5
        checks++;
        if (rd !== 8'h01) begin
            errors++; $display("FAIL filt_latency: got %h expected 01", rd);
        end
        cs = 1'b0;
        bus_read(1'b0, 3'd3, d);
        checks++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            errors++; $display("FAIL rise_disabled: got cap %h irq %b expected 00 0", d, irq);
        end
        bus_write(1'b0, 3'd5, 8'h00);
        bus_write(1'b0, 3'd4, 8'h01);
        bus_write(1'b0, 3'd2, 8'h01);
        set_input(8'h00, 10);
        bus_write(1'b0, 3'd3, 8'hFF);
        @(negedge clk);
        in_port = 8'h01; cs = 1'b1; address = 3'd3; write_n = 1'b1;
        @(posedge clk); #1;              // E0
        cyc(5);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_early: got %b expected 0", irq);
        end
        cyc(1);                          // E0+6
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_latency: got %b expected 1", irq);
        end
        cyc(1);
        checks++;
        if (rd !== 8'h01) begin
            errors++; $display("FAIL rise_capture: got %h expected 01", rd);
        end
        cs = 1'b0;
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        bus_write(1'b0, 3'd4, 8'h00);
        bus_write(1'b0, 3'd5, 8'h04);
        bus_write(1'b0, 3'd2, 8'h00);
        set_input(8'h04, 10);
        bus_write(1'b0, 3'd3, 8'hFF);
        @(negedge clk); in_port = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); in_port = 8'h04;
        cyc(12);
        bus_read(1'b0, 3'd3, d);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL glitch3_capture: got %h expected 00", d);
        end
        bus_read(1'b0, 3'd0, d);
        checks++;
        if (d !== 8'h04) begin
            errors++; $display("FAIL glitch3_filtered: got %h expected 04", d);
        end
        @(negedge clk); in_port = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk); in_port = 8'h04;
        cyc(12);
        bus_read(1'b0, 3'd3, d);
        checks++;
        if (d !== 8'h04) begin
            errors++; $display("FAIL pulse4_capture: got %h expected 04", d);
        end
    endtask

    task automatic test_w1c();
        logic [7:0] d;
        bus_write(1'b0, 3'd4, 8'h00);
        bus_write(1'b0, 3'd5, 8'h05);
        set_input(8'h05, 10);
        bus_write(1'b0, 3'd3, 8'hFF);
        set_input(8'h00, 10);
        bus_read(1'b0, 3'd3, d);
        checks++;
        if (d !== 8'h05) begin
            errors++; $display("FAIL w1c_setup: got %h expected 05", d);
        end
        bus_write(1'b0, 3'd3, 8'h01);
        bus_read(1'b0, 3'd3, d);
        checks++;
        if (d !== 8'h04) begin
            errors++; $display("FAIL w1c_single: got %h expected 04", d);
        end
        set_input(8'h04, 10);
        @(negedge clk); in_port = 8'h00;
        @(posedge clk);                  // E0
        repeat (5) @(posedge clk);       // E0+5
        bus_write(1'b0, 3'd3, 8'h04);    // lands on E0+6 with the new fall edge
        bus_read(1'b0, 3'd3, d);
        checks++;
        if (d !== 8'h04) begin
            errors++; $display("FAIL w1c_edge_wins: got %h expected 04", d);
        end
        bus_write(1'b0, 3'd3, 8'h04);
        bus_read(1'b0, 3'd3, d);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL w1c_clear: got %h expected 00", d);
        end
    endtask

    task automatic test_mask();
        logic [7:0] d;
        bus_write(1'b0, 3'd4, 8'h00);
        bus_write(1'b0, 3'd5, 8'h02);
        bus_write(1'b0, 3'd2, 8'hF0);
        set_input(8'h02, 10);
        bus_write(1'b0, 3'd3, 8'hFF);
        set_input(8'h00, 10);
        bus_read(1'b0, 3'd3, d);
        checks++;
        if (d !== 8'h02) begin
            errors++; $display("FAIL mask_capture: got %h expected 02", d);
        end
        bus_read(1'b0, 3'd6, d);
        checks++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            errors++; $display("FAIL mask_pending: got %h irq %b expected 00 0", d, irq);
        end
        bus_write(1'b0, 3'd2, 8'h02);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL unmask_irq: got %b expected 1", irq);
        end
        bus_read(1'b0, 3'd6, d);
        checks++;
        if (d !== 8'h02) begin
            errors++; $display("FAIL unmask_pending: got %h expected 02", d);
        end
        bus_write(1'b0, 3'd2, 8'h00);
        bus_read(1'b0, 3'd3, d);
        checks++;
        if (irq !== 1'b0 || d !== 8'h02) begin
            errors++; $display("FAIL remask: got irq %b cap %h expected 0 02", irq, d);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] d;
        set_input(8'h00, 5);
        bus_write(1'b1, 3'd4, 8'h80);
        bus_write(1'b1, 3'd5, 8'h00);
        bus_write(1'b1, 3'd2, 8'h80);
        bus_write(1'b1, 3'd3, 8'hFF);
        checks++;
        if (irq0 !== 1'b0) begin
            errors++; $display("FAIL bypass_idle_irq: got %b expected 0", irq0);
        end
        @(negedge clk);
        in_port = 8'h80; cs0 = 1'b1; address = 3'd3; write_n = 1'b1;
        @(posedge clk); #1;              // E0
        @(negedge clk); in_port = 8'h00;
        @(posedge clk); #1;              // E0+1
        checks++;
        if (irq0 !== 1'b0) begin
            errors++; $display("FAIL bypass_early: got %b expected 0", irq0);
        end
        cyc(1);                          // E0+2
        checks++;
        if (irq0 !== 1'b1) begin
            errors++; $display("FAIL bypass_latency: got %b expected 1", irq0);
        end
        cyc(1);
        checks++;
        if (rd0 !== 8'h80) begin
            errors++; $display("FAIL bypass_capture: got %h expected 80", rd0);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (irq0 !== 1'b0 || rd0 !== 8'h00) begin
            errors++; $display("FAIL midreset: got irq %b rd %h expected 0 00", irq0, rd0);
        end
        @(negedge clk); reset = 1'b0; cs0 = 1'b0;
        bus_read(1'b1, 3'd3, d);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL midreset_capture: got %h expected 00", d);
        end
    endtask

    // Random inputs and random W1C writes on the filtered instance, compared
    // each cycle against a window-based model: a bit's filtered level becomes v
    // once its last FL synchronised samples all equal v.
    task automatic test_random();
        logic [7:0] hist [$];
        logic [7:0] rise_m, fall_m, mask_m;
        logic [7:0] filt_m, prev_m, cap_m, exp_rd;
        logic [7:0] cur, nd, wd, clr, all1, any1, win, new_filt, set_m;
        bit         do_wr;
        rise_m = 8'($urandom_range(0, 255));
        fall_m = 8'($urandom_range(0, 255));
        mask_m = 8'($urandom_range(0, 255));
        bus_write(1'b0, 3'd4, rise_m);
        bus_write(1'b0, 3'd5, fall_m);
        bus_write(1'b0, 3'd2, mask_m);
        set_input(8'h00, 12);
        bus_write(1'b0, 3'd3, 8'hFF);
        filt_m = 8'h00; prev_m = 8'h00; cap_m = 8'h00; cur = 8'h00;
        for (int i = 0; i < S + FL; i++) hist.push_back(8'h00);
        for (int k = 0; k < 300; k++) begin
            nd = ($urandom_range(0, 3) == 0) ? (cur ^ 8'($urandom & $urandom)) : cur;
            do_wr = ($urandom_range(0, 7) == 0);
            wd = 8'($urandom_range(0, 255));
            @(negedge clk);
            in_port = nd; cur = nd;
            cs = 1'b1; address = 3'd3; write_n = !do_wr; writedata = wd;
            @(posedge clk); #1;
            hist.push_back(nd);
            all1 = 8'hFF; any1 = 8'h00;
            for (int j = 0; j < FL; j++) begin
                win = hist[hist.size() - 1 - S - j];
                all1 &= win; any1 |= win;
            end
            new_filt = all1 | (filt_m & any1);
            set_m = (filt_m & ~prev_m & rise_m) | (~filt_m & prev_m & fall_m);
            clr = do_wr ? wd : 8'h00;
            exp_rd = cap_m;
            cap_m = set_m | (cap_m & ~clr);
            prev_m = filt_m;
            filt_m = new_filt;
            if (hist.size() > 32) void'(hist.pop_front());
            checks++;
            if (rd !== exp_rd) begin
                errors++; $display("FAIL rand_capture cyc%0d: got %h expected %h", k, rd, exp_rd);
            end
            checks++;
            if (irq !== |(cap_m & mask_m)) begin
                errors++; $display("FAIL rand_irq cyc%0d: got %b expected %b", k, irq, |(cap_m & mask_m));
            end
        end
        @(negedge clk); cs = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = 3'd0; cs = 1'b0; cs0 = 1'b0;
        write_n = 1'b1; writedata = 8'h00; in_port = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_w1c();
        test_mask();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
